counter_sequencer: RTL and testbench

- Command-driven controller that sequences a wrap-around up-counter datapath: start, pause, resume and abort over a valid/ready command port.
- Each run has a programmable wrap limit and a programmable number of laps (full 0..limit passes).
- Reports count, per-wrap pulse, lap count, busy and done.
- Sits between the lab's top-level control logic (buttons/FSMs) and the counter-driven display/timing logic.

---
 rtl/counter_pkg.sv | 19 +
 rtl/wrap_counter.sv | 37 +++
 rtl/counter_sequencer.sv | 136 +++++++++++++
 tb/tb_counter_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer: controller states,
// command opcodes and the limit a freshly reset controller assumes.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;

  localparam int DEFAULT_LIMIT = 7;

endpackage

// File: rtl/wrap_counter.sv
// Wrap-around up-counter 0..limit; advances one step per enabled edge, clr wins over en.
// wrap is decoded from the registered count, so it flags the cycle holding count==limit.
module wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == limit) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = (count_q == limit);

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven start/pause/resume/abort controller over a wrap counter; state changes on the
// accepting edge. Registered cmd_ready drops for one cycle after each accept (one command per two cycles).
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [LAP_W-1:0] cmd_laps,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_err_q, cmd_err_d;

  logic             accept, illegal, wrap_ev, lap_done;
  logic             cnt_en, cnt_clr, cnt_wrap;
  logic [LAP_W-1:0] lap_inc;
  logic [WIDTH-1:0] cnt_val;

  wrap_counter #(.WIDTH(WIDTH)) u_wrap_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .limit (limit_q),
    .count (cnt_val),
    .wrap  (cnt_wrap)
  );

  always_comb begin
    accept      = cmd_valid && cmd_ready_q;
    wrap_ev     = (state_q == RUN) && cnt_wrap;
    lap_inc     = lap_cnt_q + LAP_W'(1);
    lap_done    = wrap_ev && (laps_q != '0) && (lap_inc == laps_q);
    state_d     = state_q;
    limit_d     = limit_q;
    laps_d      = laps_q;
    lap_cnt_d   = lap_cnt_q;
    cnt_en      = (state_q == RUN);
    cnt_clr     = 1'b0;
    illegal     = 1'b0;

    if (wrap_ev && (lap_cnt_q != '1)) begin
      lap_cnt_d = lap_inc;
    end
    if (lap_done) begin
      state_d = DONE;
      cnt_clr = 1'b1;
    end

    // Commands overlay the counting step: ABORT beats everything, lap completion beats PAUSE.
    if (accept) begin
      if ((cmd_op == OP_ABORT) && (state_q != IDLE)) begin
        state_d   = IDLE;
        lap_cnt_d = '0;
        cnt_clr   = 1'b1;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (cmd_op == OP_START) begin
              state_d   = RUN;
              limit_d   = cmd_limit;
              laps_d    = cmd_laps;
              lap_cnt_d = '0;
              cnt_clr   = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          RUN: begin
            // RESUME while already running is treated as illegal, like START.
            if (cmd_op == OP_PAUSE) begin
              if (!lap_done) state_d = PAUSE;
            end else begin
              illegal = 1'b1;
            end
          end
          PAUSE: begin
            if (cmd_op == OP_RESUME) begin
              state_d = RUN;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
    end

    cmd_ready_d = !accept;
    cmd_err_d   = illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      limit_q     <= WIDTH'(DEFAULT_LIMIT);
      laps_q      <= '0;
      lap_cnt_q   <= '0;
      cmd_ready_q <= 1'b1;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_q     <= limit_d;
      laps_q      <= laps_d;
      lap_cnt_q   <= lap_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign count     = cnt_val;
  assign wrap      = wrap_ev;
  assign lap_cnt   = lap_cnt_q;
  assign busy      = (state_q == RUN) || (state_q == PAUSE);
  assign done      = (state_q == DONE);
  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: vector table, directed corner sequences and random commands,
// every cycle also compared against a cycle-level behavioural model.
module tb_counter_sequencer;
  import counter_pkg::*;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_limit;
  logic [3:0] cmd_laps;
  logic [3:0] count;
  logic       wrap;
  logic [3:0] lap_cnt;
  logic       busy;
  logic       done;
  logic       cmd_err;

  counter_sequencer #(.WIDTH(4), .LAP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_limit (cmd_limit),
    .cmd_laps  (cmd_laps),
    .count     (count),
    .wrap      (wrap),
    .lap_cnt   (lap_cnt),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // {count, lap_cnt, wrap, busy, done, cmd_ready, cmd_err}
  logic [12:0] dut_vec;
  assign dut_vec = {count, lap_cnt, wrap, busy, done, cmd_ready, cmd_err};

  int checks = 0;
  int failures = 0;

  int m_st, m_cnt, m_lap, m_lim, m_laps;
  bit m_rdy, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_cnt = 0; m_lap = 0; m_lim = 7; m_laps = 0; m_rdy = 1; m_err = 0;
  endtask

  // One clock edge: run the counter for the state held before the edge, then apply the command.
  task automatic model_step(input bit v, input int op, input int lim, input int laps);
    bit acc;
    int st0, lap0;
    acc = v && m_rdy;
    st0 = m_st;
    lap0 = m_lap;
    m_err = 0;
    m_rdy = !acc;
    if (st0 == S_RUN) begin
      if (m_cnt == m_lim) begin
        m_cnt = 0;
        m_lap = (lap0 < 15) ? lap0 + 1 : 15;
        if (m_laps != 0 && lap0 + 1 == m_laps) m_st = S_DONE;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (acc) begin
      if (op == 3 && st0 != S_IDLE) begin
        m_st = S_IDLE; m_cnt = 0; m_lap = 0;
      end else if (op == 0 && (st0 == S_IDLE || st0 == S_DONE)) begin
        m_st = S_RUN; m_cnt = 0; m_lap = 0; m_lim = lim; m_laps = laps;
      end else if (op == 1 && st0 == S_RUN) begin
        if (m_st == S_RUN) m_st = S_PAUSE;
      end else if (op == 2 && st0 == S_PAUSE) begin
        m_st = S_RUN;
      end else begin
        m_err = 1;
      end
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic w;
    w = (m_st == S_RUN) && (m_cnt == m_lim);
    return {4'(m_cnt), 4'(m_lap), w, (m_st == S_RUN || m_st == S_PAUSE), (m_st == S_DONE), m_rdy, m_err};
  endfunction

  // Called just after a falling edge: drive, take one rising edge, compare on the next falling edge.
  task automatic cyc(input bit v, input logic [1:0] op, input logic [3:0] lim, input logic [3:0] laps);
    cmd_valid = v; cmd_op = op; cmd_limit = lim; cmd_laps = laps;
    @(posedge clk);
    model_step(v, int'(op), int'(lim), int'(laps));
    @(negedge clk);
    check("model", dut_vec, model_vec());
  endtask

  task automatic idle();
    cyc(1'b0, OP_START, 4'd0, 4'd0);
  endtask

  typedef struct {
    bit         v;
    logic [1:0] op;
    logic [3:0] lim;
    logic [3:0] laps;
    logic [3:0] e_cnt;
    logic [3:0] e_lap;
    logic       e_wrap, e_busy, e_done, e_rdy, e_err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // limit=0, laps=3; then illegal/throttled commands in DONE and IDLE.
    tbl[0]  = '{1'b1, OP_START,  4'd0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, OP_START,  4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, OP_START,  4'd0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, OP_START,  4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, OP_PAUSE,  4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, OP_ABORT,  4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, OP_ABORT,  4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, OP_START,  4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, OP_START,  4'd5, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, OP_ABORT,  4'd5, 4'd0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, OP_ABORT,  4'd5, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, OP_RESUME, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, OP_RESUME, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, OP_START,  4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_START; cmd_limit = '0; cmd_laps = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", dut_vec, {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].op, tbl[i].lim, tbl[i].laps);
      check($sformatf("table_%0d", i), dut_vec,
            {tbl[i].e_cnt, tbl[i].e_lap, tbl[i].e_wrap, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_rdy, tbl[i].e_err});
    end

    // Bounded run: limit=7, laps=2 gives 16 RUN cycles then DONE.
    cyc(1'b1, OP_START, 4'd7, 4'd2);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) idle();
      check($sformatf("bounded_%0d", j), {count, lap_cnt, wrap, busy},
            {4'(j % 8), 4'(j / 8), (j % 8 == 7), 1'b1});
    end
    idle();
    check("bounded_done", {count, lap_cnt, done, busy}, {4'd0, 4'd2, 1'b1, 1'b0});

    // Pause/resume with limit=3, run forever.
    cyc(1'b1, OP_ABORT, 4'd0, 4'd0);
    idle();
    cyc(1'b1, OP_START, 4'd3, 4'd0);
    idle();
    cyc(1'b1, OP_PAUSE, 4'd0, 4'd0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) idle();
      check($sformatf("paused_%0d", j), {count, wrap, busy}, {4'd2, 1'b0, 1'b1});
    end
    cyc(1'b1, OP_RESUME, 4'd0, 4'd0);
    check("resume_edge", {count, wrap, busy}, {4'd2, 1'b0, 1'b1});
    idle();
    check("resume_wrap", {count, wrap}, {4'd3, 1'b1});
    idle();
    check("resume_after_wrap", {count, lap_cnt}, {4'd0, 4'd1});
    idle();
    idle();
    idle();
    check("pre_pause_wrap", {count, wrap}, {4'd3, 1'b1});
    cyc(1'b1, OP_PAUSE, 4'd0, 4'd0);
    check("pause_on_wrap", {count, lap_cnt, wrap, busy, done}, {4'd0, 4'd2, 1'b0, 1'b1, 1'b0});

    // Same collision on the final lap: DONE beats PAUSE.
    idle();
    cyc(1'b1, OP_ABORT, 4'd0, 4'd0);
    idle();
    cyc(1'b1, OP_START, 4'd3, 4'd1);
    repeat (3) idle();
    cyc(1'b1, OP_PAUSE, 4'd0, 4'd0);
    check("pause_on_last_wrap", {count, lap_cnt, busy, done, cmd_err}, {4'd0, 4'd1, 1'b0, 1'b1, 1'b0});

    // Asynchronous reset mid-run, then an illegal PAUSE from IDLE.
    idle();
    cyc(1'b1, OP_START, 4'd7, 4'd0);
    repeat (5) idle();
    check("pre_reset_count", count, 4'd5);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset", dut_vec, {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, OP_PAUSE, 4'd0, 4'd0);
    check("illegal_err", {cmd_err, busy, done, count}, {1'b1, 1'b0, 1'b0, 4'd0});
    idle();
    check("illegal_err_clears", {cmd_err, busy}, {1'b0, 1'b0});

    // Random commands against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] rop;
      logic [3:0] rlim, rlaps;
      rop   = 2'($urandom_range(0, 3));
      rlim  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      rlaps = 4'($urandom_range(0, 3));
      cyc(($urandom_range(0, 99) < 40), rop, rlim, rlaps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
